// File: rtl/dual_port_ram_gen.sv
// ---------------------------------------------------------------------------
// dual_port_ram_gen
//   Simple dual-port RAM with one clock. Port A can write and read at the
//   same address, while port B is read-only. After every reset the block
//   clears the whole array with an internal counter before it accepts any
//   port activity. Same-address read-during-write returns either the old
//   word (RDW_MODE = 0) or the incoming word (RDW_MODE = 1).
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   wea        port A write enable
//   rea        port A read enable
//   addra      port A address (write and read)
//   dina       port A write data
//   reb        port B read enable
//   addrb      port B read address
//   douta      port A registered read data
//   valida     douta was updated by the last edge
//   doutb      port B registered read data
//   validb     doutb was updated by the last edge
//   init_busy  memory clear in progress; port activity is ignored
// ---------------------------------------------------------------------------
module dual_port_ram_gen #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wea,
  input  logic              rea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              reb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] douta,
  output logic              valida,
  output logic [DATA_W-1:0] doutb,
  output logic              validb,
  output logic              init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              fwd_a;
  logic              fwd_b;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Leave INIT on the edge that clears the last address. The counter is
  // all ones exactly when it points at DEPTH-1.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (&clr_cnt) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  assign ready     = (state == READY);
  assign init_busy = (state == INIT);

  // The clear counter only advances during INIT. Every reset returns it to 0,
  // so the full sweep is repeated after each reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end

  // A single write port is shared between the clear sweep and user writes.
  // Writes are blocked while rst is high, so a write already in progress
  // when reset arrives never reaches the array.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addra;
    wr_data = dina;
    if (!rst) begin
      if (state == INIT) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
      end else begin
        wr_en = wea;
      end
    end
  end

  // The array itself has no reset. Its contents are only zeroed by the sweep.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Write-first forwarding. Read-first needs no extra logic, because the
  // array read sees the value from before the nonblocking write.
  assign fwd_a = (RDW_MODE == 1) && wea;
  assign fwd_b = (RDW_MODE == 1) && wea && (addrb == addra);

  // Registered read ports. The data outputs keep their value whenever they
  // are not loaded, and the valid flags are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      douta  <= '0;
      doutb  <= '0;
      valida <= 1'b0;
      validb <= 1'b0;
    end else begin
      valida <= ready && rea;
      validb <= ready && reb;
      if (ready && rea) begin
        douta <= fwd_a ? dina : mem[addra];
      end
      if (ready && reb) begin
        doutb <= fwd_b ? dina : mem[addrb];
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_gen.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram_gen
//   Self-checking bench for dual_port_ram_gen. Three instances share one
//   clock and one reset:
//     u_rf   DATA_W=8,  ADDR_W=4, read-first
//     u_wf   DATA_W=8,  ADDR_W=4, write-first (same inputs as u_rf)
//     u_wide DATA_W=32, ADDR_W=6, read-first
//   A behavioural model keeps arrays of words, a count of remaining clear
//   cycles, and the expected output values. Each scenario task drives
//   inputs, advances one clock with cycle(), and compares the outputs with
//   the model or with fixed values.
// ---------------------------------------------------------------------------
module tb_dual_port_ram_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        wea_n = 1'b0, rea_n = 1'b0, reb_n = 1'b0;
  logic [3:0]  addra_n = '0, addrb_n = '0;
  logic [7:0]  dina_n = '0;
  logic [7:0]  douta_rf, doutb_rf, douta_wf, doutb_wf;
  logic        valida_rf, validb_rf, busy_rf, valida_wf, validb_wf, busy_wf;

  logic        wea_w = 1'b0, rea_w = 1'b0, reb_w = 1'b0;
  logic [5:0]  addra_w = '0, addrb_w = '0;
  logic [31:0] dina_w = '0;
  logic [31:0] douta_w, doutb_w;
  logic        valida_w, validb_w, busy_w;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [7:0]  m_rf [16];
  logic [7:0]  m_wf [16];
  logic [31:0] m_w  [64];
  int          left_n, left_w;
  logic [7:0]  ea_rf, eb_rf, ea_wf, eb_wf;
  logic [31:0] ea_w, eb_w;
  logic        va_rf, vb_rf, va_wf, vb_wf, va_w, vb_w;

  always #5 clk = ~clk;

  dual_port_ram_gen #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(0)) u_rf (
    .clk(clk), .rst(rst), .wea(wea_n), .rea(rea_n), .addra(addra_n),
    .dina(dina_n), .reb(reb_n), .addrb(addrb_n), .douta(douta_rf),
    .valida(valida_rf), .doutb(doutb_rf), .validb(validb_rf),
    .init_busy(busy_rf));

  dual_port_ram_gen #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(1)) u_wf (
    .clk(clk), .rst(rst), .wea(wea_n), .rea(rea_n), .addra(addra_n),
    .dina(dina_n), .reb(reb_n), .addrb(addrb_n), .douta(douta_wf),
    .valida(valida_wf), .doutb(doutb_wf), .validb(validb_wf),
    .init_busy(busy_wf));

  dual_port_ram_gen #(.DATA_W(32), .ADDR_W(6), .RDW_MODE(0)) u_wide (
    .clk(clk), .rst(rst), .wea(wea_w), .rea(rea_w), .addra(addra_w),
    .dina(dina_w), .reb(reb_w), .addrb(addrb_w), .douta(douta_w),
    .valida(valida_w), .doutb(doutb_w), .validb(validb_w),
    .init_busy(busy_w));

  // Update the model from the inputs currently applied, then let one rising
  // edge pass and return 1 time unit after it.
  task automatic cycle();
    if (rst) begin
      left_n = 16; left_w = 64;
      ea_rf = '0; eb_rf = '0; ea_wf = '0; eb_wf = '0; ea_w = '0; eb_w = '0;
      va_rf = 0; vb_rf = 0; va_wf = 0; vb_wf = 0; va_w = 0; vb_w = 0;
      // The clear sweep runs before any read is possible, so the model can
      // treat the array as all zero from the moment of reset.
      for (int i = 0; i < 16; i++) begin m_rf[i] = '0; m_wf[i] = '0; end
      for (int i = 0; i < 64; i++) m_w[i] = '0;
    end else begin
      if (left_n > 0) begin
        left_n--;
        va_rf = 0; vb_rf = 0; va_wf = 0; vb_wf = 0;
      end else begin
        va_rf = rea_n; vb_rf = reb_n; va_wf = rea_n; vb_wf = reb_n;
        if (rea_n) begin
          ea_rf = m_rf[addra_n];
          ea_wf = wea_n ? dina_n : m_wf[addra_n];
        end
        if (reb_n) begin
          eb_rf = m_rf[addrb_n];
          eb_wf = (wea_n && addrb_n == addra_n) ? dina_n : m_wf[addrb_n];
        end
        if (wea_n) begin m_rf[addra_n] = dina_n; m_wf[addra_n] = dina_n; end
      end
      if (left_w > 0) begin
        left_w--;
        va_w = 0; vb_w = 0;
      end else begin
        va_w = rea_w; vb_w = reb_w;
        if (rea_w) ea_w = m_w[addra_w];
        if (reb_w) eb_w = m_w[addrb_w];
        if (wea_w) m_w[addra_w] = dina_w;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wea_n = 0; rea_n = 0; reb_n = 0;
    wea_w = 0; rea_w = 0; reb_w = 0;
  endtask

  // While reset is held, everything must read zero and busy must be high,
  // whatever happens on the ports.
  task automatic test_reset();
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      wea_n = 1; rea_n = 1; reb_n = 1;
      addra_n = 4'($urandom); addrb_n = 4'($urandom); dina_n = 8'($urandom);
      wea_w = 1; rea_w = 1; reb_w = 1;
      addra_w = 6'($urandom); addrb_w = 6'($urandom); dina_w = $urandom;
      cycle();
      total++;
      if ({douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf,
           douta_wf, doutb_wf, valida_wf, validb_wf, busy_wf,
           douta_w, doutb_w, valida_w, validb_w, busy_w} !==
          {8'h0, 8'h0, 3'b001, 8'h0, 8'h0, 3'b001, 32'h0, 32'h0, 3'b001}) begin
        bad++;
        $display("[TB] FAIL reset_hold k=%0d: got rf=%h/%h/%b%b%b wide=%h/%h/%b%b%b want zeros with busy=1",
                 k, douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf,
                 douta_w, doutb_w, valida_w, validb_w, busy_w);
      end
    end
  endtask

  // Release reset while both reads stay enabled and writes are attempted
  // during INIT. The writes must be ignored and no valid may appear until the
  // clear finishes. The first reads afterwards must return zero.
  task automatic test_init();
    int busy_n_cnt = 0, busy_w_cnt = 0;
    rst = 0;
    for (int k = 0; k < 70; k++) begin
      rea_n = 1; reb_n = 1; rea_w = 1; reb_w = 1;
      wea_n = (left_n > 0) ? 1'($urandom) : 1'b0;
      wea_w = (left_w > 0) ? 1'($urandom) : 1'b0;
      addra_n = 4'($urandom); addrb_n = 4'($urandom); dina_n = 8'($urandom);
      addra_w = 6'($urandom); addrb_w = 6'($urandom); dina_w = $urandom;
      cycle();
      busy_n_cnt += busy_rf ? 1 : 0;
      busy_w_cnt += busy_w ? 1 : 0;
      total++;
      if ({douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf} !==
          {ea_rf, eb_rf, va_rf, vb_rf, left_n > 0}) begin
        bad++;
        $display("[TB] FAIL init_rf k=%0d: got %h %h %b%b%b want %h %h %b%b%b", k,
                 douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf,
                 ea_rf, eb_rf, va_rf, vb_rf, left_n > 0);
      end
      total++;
      if ({douta_wf, doutb_wf, valida_wf, validb_wf, busy_wf} !==
          {ea_wf, eb_wf, va_wf, vb_wf, left_n > 0}) begin
        bad++;
        $display("[TB] FAIL init_wf k=%0d: got %h %h %b%b%b want %h %h %b%b%b", k,
                 douta_wf, doutb_wf, valida_wf, validb_wf, busy_wf,
                 ea_wf, eb_wf, va_wf, vb_wf, left_n > 0);
      end
      total++;
      if ({douta_w, doutb_w, valida_w, validb_w, busy_w} !==
          {ea_w, eb_w, va_w, vb_w, left_w > 0}) begin
        bad++;
        $display("[TB] FAIL init_wide k=%0d: got %h %h %b%b%b want %h %h %b%b%b", k,
                 douta_w, doutb_w, valida_w, validb_w, busy_w,
                 ea_w, eb_w, va_w, vb_w, left_w > 0);
      end
    end
    // Busy is seen after edges 1..DEPTH-1 and drops on edge DEPTH.
    total++;
    if (busy_n_cnt != 15 || busy_w_cnt != 63) begin
      bad++;
      $display("[TB] FAIL init_length: got busy samples %0d/%0d want 15/63",
               busy_n_cnt, busy_w_cnt);
    end
    idle_inputs();
  endtask

  // Write followed by a read on both ports, then an idle cycle.
  task automatic test_write_read();
    idle_inputs();
    wea_n = 1; addra_n = 4'd3; dina_n = 8'hA5;
    cycle();
    wea_n = 0; rea_n = 1; reb_n = 1; addrb_n = 4'd3;
    cycle();
    total++;
    if ({douta_rf, doutb_rf, valida_rf, validb_rf, douta_wf, doutb_wf, valida_wf, validb_wf} !==
        {8'hA5, 8'hA5, 2'b11, 8'hA5, 8'hA5, 2'b11}) begin
      bad++;
      $display("[TB] FAIL wr_rd_a5: got rf %h %h %b%b wf %h %h %b%b want a5 a5 11",
               douta_rf, doutb_rf, valida_rf, validb_rf, douta_wf, doutb_wf, valida_wf, validb_wf);
    end
    idle_inputs();
    cycle();
    total++;
    if ({douta_rf, doutb_rf, valida_rf, validb_rf} !== {8'hA5, 8'hA5, 2'b00}) begin
      bad++;
      $display("[TB] FAIL wr_rd_hold: got %h %h %b%b want a5 a5 00",
               douta_rf, doutb_rf, valida_rf, validb_rf);
    end
  endtask

  // Same-address read during a write: read-first returns the old word and
  // write-first returns the new one. A later read sees the new word.
  task automatic test_rdw();
    idle_inputs();
    wea_n = 1; addra_n = 4'd5; dina_n = 8'h11;
    cycle();
    wea_n = 1; dina_n = 8'h22; rea_n = 1; reb_n = 1; addrb_n = 4'd5;
    cycle();
    total++;
    if ({douta_rf, doutb_rf} !== {8'h11, 8'h11}) begin
      bad++;
      $display("[TB] FAIL rdw_read_first: got %h %h want 11 11", douta_rf, doutb_rf);
    end
    total++;
    if ({douta_wf, doutb_wf} !== {8'h22, 8'h22}) begin
      bad++;
      $display("[TB] FAIL rdw_write_first: got %h %h want 22 22", douta_wf, doutb_wf);
    end
    wea_n = 0;
    cycle();
    total++;
    if ({douta_rf, doutb_rf, douta_wf, doutb_wf} !== {4{8'h22}}) begin
      bad++;
      $display("[TB] FAIL rdw_after: got %h %h %h %h want 22", douta_rf, doutb_rf, douta_wf, doutb_wf);
    end
    idle_inputs();
  endtask

  // Wide instance: words at both address extremes, read in the same cycle.
  task automatic test_wide();
    idle_inputs();
    wea_w = 1; addra_w = 6'd63; dina_w = 32'hDEADBEEF;
    cycle();
    addra_w = 6'd0; dina_w = 32'h1;
    cycle();
    wea_w = 0; rea_w = 1; reb_w = 1; addra_w = 6'd63; addrb_w = 6'd0;
    cycle();
    total++;
    if ({douta_w, doutb_w, valida_w, validb_w} !== {32'hDEADBEEF, 32'h1, 2'b11}) begin
      bad++;
      $display("[TB] FAIL wide_extremes: got %h %h %b%b want deadbeef 00000001 11",
               douta_w, doutb_w, valida_w, validb_w);
    end
    idle_inputs();
  endtask

  // Random traffic on all ports. Addresses come from a narrow window so that
  // collisions and same-address reads happen often.
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      wea_n = 1'($urandom); rea_n = 1'($urandom); reb_n = 1'($urandom);
      addra_n = 4'($urandom_range(0, 5)); dina_n = 8'($urandom);
      addrb_n = ($urandom_range(0, 3) == 0) ? addra_n : 4'($urandom_range(0, 5));
      wea_w = 1'($urandom); rea_w = 1'($urandom); reb_w = 1'($urandom);
      addra_w = 6'($urandom); dina_w = $urandom;
      addrb_w = ($urandom_range(0, 3) == 0) ? addra_w : 6'($urandom);
      cycle();
      total++;
      if ({douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf,
           douta_wf, doutb_wf, valida_wf, validb_wf, busy_wf} !==
          {ea_rf, eb_rf, va_rf, vb_rf, 1'b0, ea_wf, eb_wf, va_wf, vb_wf, 1'b0}) begin
        bad++;
        $display("[TB] FAIL rnd_narrow k=%0d: got rf %h %h %b%b%b wf %h %h %b%b%b want rf %h %h %b%b wf %h %h %b%b",
                 k, douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf,
                 douta_wf, doutb_wf, valida_wf, validb_wf, busy_wf,
                 ea_rf, eb_rf, va_rf, vb_rf, ea_wf, eb_wf, va_wf, vb_wf);
      end
      total++;
      if ({douta_w, doutb_w, valida_w, validb_w, busy_w} !== {ea_w, eb_w, va_w, vb_w, 1'b0}) begin
        bad++;
        $display("[TB] FAIL rnd_wide k=%0d: got %h %h %b%b%b want %h %h %b%b0", k,
                 douta_w, doutb_w, valida_w, validb_w, busy_w, ea_w, eb_w, va_w, vb_w);
      end
    end
    idle_inputs();
  endtask

  // Reset arriving in the middle of a write. The outputs must clear without
  // waiting for a clock edge, the full clear must run again, and the
  // interrupted write must leave nothing behind.
  task automatic test_reset_mid();
    idle_inputs();
    wea_n = 1; addra_n = 4'd7; dina_n = 8'h3C;
    cycle();
    wea_n = 0; rea_n = 1;
    cycle();
    total++;
    if (douta_rf !== 8'h3C || valida_rf !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_readback: got %h v=%b want 3c v=1", douta_rf, valida_rf);
    end
    wea_n = 1; dina_n = 8'hFF; rea_n = 1;
    #2;
    rst = 1;
    #1;
    total++;
    if ({douta_rf, valida_rf, busy_rf, douta_wf, busy_wf, douta_w, busy_w} !==
        {8'h0, 2'b01, 8'h0, 1'b1, 32'h0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL mid_async: got rf %h v=%b b=%b wf %h b=%b wide %h b=%b want 0 with busy=1",
               douta_rf, valida_rf, busy_rf, douta_wf, busy_wf, douta_w, busy_w);
    end
    cycle();
    rst = 0;
    wea_n = 0;
    for (int k = 0; k < 66; k++) begin
      rea_n = 1; reb_n = 1; addra_n = 4'd7; addrb_n = 4'($urandom);
      cycle();
      total++;
      if ({douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf} !==
          {ea_rf, eb_rf, va_rf, vb_rf, left_n > 0}) begin
        bad++;
        $display("[TB] FAIL mid_reinit k=%0d: got %h %h %b%b%b want %h %h %b%b%b", k,
                 douta_rf, doutb_rf, valida_rf, validb_rf, busy_rf,
                 ea_rf, eb_rf, va_rf, vb_rf, left_n > 0);
      end
      total++;
      if (busy_w !== (left_w > 0)) begin
        bad++;
        $display("[TB] FAIL mid_reinit_wide k=%0d: got busy=%b want %b", k, busy_w, left_w > 0);
      end
    end
    total++;
    if (douta_rf !== 8'h00 || douta_wf !== 8'h00) begin
      bad++;
      $display("[TB] FAIL mid_cleared: got %h %h want 00", douta_rf, douta_wf);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_rdw();
    test_wide();
    test_random();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_gen.md
DUAL_PORT_RAM_GEN -- requirements
Module: dual_port_ram_gen

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits (DATA_W >= 1).
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; depth SHALL be DEPTH = 2**ADDR_W words.
REQ-003 Parameter RDW_MODE, default 0, SHALL select same-address read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 The port list SHALL be, clock and reset first:
  clk  input  1  single clock, all state on rising edge
  rst  input  1  asynchronous, active-high reset
  wea  input  1  port A write enable
  rea  input  1  port A read enable
  addra  input  ADDR_W  port A address (write and read)
  dina  input  DATA_W  port A write data
  reb  input  1  port B read enable
  addrb  input  ADDR_W  port B read address
  douta  output  DATA_W  port A registered read data
  valida  output  1  douta updated this cycle
  doutb  output  DATA_W  port B registered read data
  validb  output  1  doutb updated this cycle
  init_busy  output  1  memory clear in progress, ports ignored

Function
REQ-005 The block SHALL contain a two-state FSM: INIT and READY.
REQ-006 In INIT, an ADDR_W-bit clear counter SHALL write 0 to mem[counter] each cycle, incrementing from 0 to DEPTH-1.
REQ-007 The FSM SHALL move INIT -> READY on the edge that clears address DEPTH-1; INIT SHALL last exactly DEPTH cycles after reset release.
REQ-008 init_busy SHALL be 1 in INIT and 0 in READY, driven directly from state.
REQ-009 In INIT, wea, rea and reb SHALL be ignored: no user write, valida = validb = 0, douta/doutb hold.
REQ-010 In READY, wea = 1 SHALL write dina to mem[addra] on the rising edge.
REQ-011 In READY, rea = 1 SHALL load douta with mem[addra] and assert valida for exactly the following cycle (latency 1).
REQ-012 In READY, reb = 1 SHALL load doutb with mem[addrb] and assert validb for exactly the following cycle (latency 1).
REQ-013 With rea = 0 (reb = 0), douta (doutb) SHALL hold its last value and valida (validb) SHALL be 0.
REQ-014 Port A read with wea = 1 in the same cycle SHALL return dina when RDW_MODE = 1, the pre-write contents when RDW_MODE = 0.
REQ-015 Port B read with wea = 1 and addrb == addra SHALL follow the same RDW_MODE rule; addrb != addra SHALL return mem[addrb] unaffected.
REQ-016 Both ports reading the same address in the same cycle SHALL return identical data.
REQ-017 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-018 While rst = 1: state = INIT, clear counter = 0, douta = doutb = 0, valida = validb = 0, init_busy = 1, all asynchronously.
REQ-019 rst asserted mid-operation (INIT or READY, including during a write) SHALL abort the operation and, after release, restart the full DEPTH-cycle clear.
REQ-020 Memory contents SHALL NOT be reset directly; they SHALL be zeroed only by the INIT sequence.

Verification
REQ-021 Defaults, release rst, hold rea = reb = 1 -> init_busy = 1 for 16 cycles then 0; valida/validb stay 0 throughout INIT; first reads in READY return 0.
REQ-022 READY: write 0xA5 to addr 3, next cycle rea = 1 addra = 3 and reb = 1 addrb = 3 -> douta = doutb = 0xA5, valida = validb = 1 for one cycle, then valids 0 and data held.
REQ-023 RDW_MODE = 0: addr 5 holds 0x11; wea = 1 dina = 0x22 addra = 5, rea = 1, reb = 1 addrb = 5 -> douta = doutb = 0x11; next read of addr 5 returns 0x22. Repeat with RDW_MODE = 1 -> douta = doutb = 0x22.
REQ-024 Write 0x3C to addr 7, read it back as 0x3C, assert rst for one cycle mid-write of 0xFF to addr 7 -> outputs 0 immediately, 16-cycle INIT re-runs, addr 7 reads 0x00.
REQ-025 DATA_W = 32, ADDR_W = 6: write 0xDEADBEEF to addr 63 and 0x1 to addr 0; simultaneous reads of both -> douta = 0xDEADBEEF, doutb = 0x00000001; INIT lasts 64 cycles.
